// File: rtl/fft_peak_finder_if.sv
// rtl/fft_peak_finder_if.sv - bin stream in, per-frame peak report out
interface fft_peak_finder_if #(
  parameter int bit_width = 16,
  parameter int N         = 32
);
  localparam int M = $clog2(N);

  logic                        in_valid;
  logic signed [bit_width-1:0] in_re;
  logic signed [bit_width-1:0] in_im;
  logic                        busy;
  logic                        peak_valid;
  logic [M-1:0]                peak_bin;
  logic [bit_width:0]          peak_mag;
  logic                        peak_found;
  logic                        overrun;

  modport slave (
    input  in_valid, in_re, in_im,
    output busy, peak_valid, peak_bin, peak_mag, peak_found, overrun
  );

  modport master (
    output in_valid, in_re, in_im,
    input  busy, peak_valid, peak_bin, peak_mag, peak_found, overrun
  );
endinterface

// File: rtl/fft_peak_finder.sv
// rtl/fft_peak_finder.sv - strongest positive-frequency FFT bin per frame
// Optional macro PEAK_THRESH_EN: report a peak only when its magnitude reaches THRESH.
module fft_peak_finder #(
  parameter int bit_width = 16,
  parameter int N         = 32,
  parameter int MIN_BIN   = 1,
  parameter int THRESH    = 64
) (
  input logic               clk,
  input logic               reset,
  fft_peak_finder_if.slave  bus
);
  localparam int M = $clog2(N);
  localparam logic [M-1:0] LAST_IDX = M'(N - 1);
  localparam logic [M-1:0] MIN_IDX  = M'(MIN_BIN);
  localparam logic [M-1:0] MAX_IDX  = M'(N / 2 - 1);
  localparam logic signed [bit_width-1:0] MOST_NEG = {1'b1, {(bit_width-1){1'b0}}};
  localparam logic [bit_width-1:0]        MAX_POS  = {1'b0, {(bit_width-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN1, DRAIN2, REPORT} state_t;

  state_t              state, next_state;
  logic                accept, set_overrun;
  logic [M-1:0]        idx_now, bin_cnt;

  logic                s1_valid;
  logic [bit_width-1:0] s1_a, s1_b;
  logic [M-1:0]        s1_idx;
  logic                s2_valid;
  logic [bit_width:0]  s2_mag;
  logic [M-1:0]        s2_idx;

  logic [bit_width:0]  best_mag, base_mag;
  logic [M-1:0]        best_bin, base_bin;
  logic [bit_width-1:0] mx, mn;
  logic                candidate;

  logic                peak_valid_r, peak_found_r, overrun_r;
  logic [M-1:0]        peak_bin_r;
  logic [bit_width:0]  peak_mag_r;

  function automatic logic [bit_width-1:0] abs_sat(input logic signed [bit_width-1:0] v);
    if (v == MOST_NEG)
      return MAX_POS;
    else if (v[bit_width-1])
      return bit_width'(-v);
    else
      return bit_width'(v);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    set_overrun = 1'b0;
    idx_now     = (state == IDLE) ? '0 : bin_cnt;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          next_state = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          if (bin_cnt == LAST_IDX) next_state = DRAIN1;
        end
      end
      DRAIN1: begin
        set_overrun = bus.in_valid;
        next_state  = DRAIN2;
      end
      DRAIN2: begin
        set_overrun = bus.in_valid;
        next_state  = REPORT;
      end
      REPORT: begin
        set_overrun = bus.in_valid;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bin 0 of a frame compares against zero, so the previous frame's best never leaks in.
  always_comb begin
    mx        = (s1_a >= s1_b) ? s1_a : s1_b;
    mn        = (s1_a >= s1_b) ? s1_b : s1_a;
    candidate = (s2_idx >= MIN_IDX) && (s2_idx <= MAX_IDX);
    base_mag  = (s2_idx == '0) ? '0 : best_mag;
    base_bin  = (s2_idx == '0) ? '0 : best_bin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_cnt      <= '0;
      s1_valid     <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_idx       <= '0;
      s2_valid     <= 1'b0;
      s2_mag       <= '0;
      s2_idx       <= '0;
      best_mag     <= '0;
      best_bin     <= '0;
      peak_valid_r <= 1'b0;
      peak_bin_r   <= '0;
      peak_mag_r   <= '0;
      peak_found_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        bin_cnt <= idx_now + 1'b1;
        s1_a    <= abs_sat(bus.in_re);
        s1_b    <= abs_sat(bus.in_im);
        s1_idx  <= idx_now;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mag <= {1'b0, mx} + {2'b00, mn[bit_width-1:1]};
        s2_idx <= s1_idx;
      end
      if (s2_valid) begin
        if (candidate && (s2_mag > base_mag)) begin
          best_mag <= s2_mag;
          best_bin <= s2_idx;
        end else begin
          best_mag <= base_mag;
          best_bin <= base_bin;
        end
      end
      peak_valid_r <= (state == REPORT);
      if (state == REPORT) begin
`ifdef PEAK_THRESH_EN
        if (best_mag >= (bit_width+1)'(THRESH)) begin
          peak_found_r <= 1'b1;
          peak_bin_r   <= best_bin;
          peak_mag_r   <= best_mag;
        end else begin
          peak_found_r <= 1'b0;
          peak_bin_r   <= '0;
          peak_mag_r   <= '0;
        end
`else
        peak_found_r <= 1'b1;
        peak_bin_r   <= best_bin;
        peak_mag_r   <= best_mag;
`endif
      end
      if (set_overrun) overrun_r <= 1'b1;
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.peak_valid = peak_valid_r;
  assign bus.peak_bin   = peak_bin_r;
  assign bus.peak_mag   = peak_mag_r;
  assign bus.peak_found = peak_found_r;
  assign bus.overrun    = overrun_r;
endmodule

// File: doc/fft_peak_finder.md
Name: fft_peak_finder

Overview:
- Downstream consumer of the FFT processor's done-state readout.
- Receives the N complex bins in natural order, one per in_valid strobe, and computes an approximate magnitude per bin.
- Tracks the largest-magnitude bin within the positive-frequency search range and reports its index and magnitude once per frame.
- Its output feeds the tuner's pitch/note logic.

Parameters:
bit_width, 16, width of each signed real/imag component
N, 32, FFT length (bins per frame), power of two
M, $clog2(N), bin index width
MIN_BIN, 1, lowest bin searched (bins below it, e.g. DC, are ignored)
THRESH, 64, minimum magnitude counted as a valid peak (used only with PEAK_THRESH_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  one bin presented this cycle
in_re  input  bit_width  signed real part of the current bin
in_im  input  bit_width  signed imaginary part of the current bin
busy  output  1  frame in progress (states COLLECT/DRAIN/REPORT)
peak_valid  output  1  one-cycle pulse: peak_bin/peak_mag/peak_found updated
peak_bin  output  M  index of the strongest bin of the last frame
peak_mag  output  bit_width+1  unsigned magnitude of that bin
peak_found  output  1  peak qualifies (see Optional Feature)
overrun  output  1  sticky: in_valid arrived while in DRAIN or REPORT

Behaviour:
- Reset (clk, reset: synchronous, active-high) clears all state and outputs to 0:
  - state=IDLE, bin counter, pipeline registers, best_mag/best_bin.
  - busy, peak_valid, peak_bin, peak_mag, peak_found, overrun.
- Reset mid-frame abandons the frame; no peak_valid is produced for it.
- Bin numbering: an internal counter assigns index 0 to the first in_valid after IDLE and increments per in_valid (in_valid may have gaps). Bins arrive in order 0..N-1.
- Magnitude, pipeline stage 1 (registered):
  - a=|in_re|, b=|in_im|, computed on bit_width bits.
  - The most negative value saturates to 2^(bit_width-1)-1.
  - The bin index is registered alongside.
- Magnitude, stage 2 (registered): mag = max(a,b) + (min(a,b)>>1), unsigned bit_width+1 bits, no overflow possible.
- Compare:
  - Only bins with MIN_BIN <= idx <= N/2-1 are candidates.
  - A candidate replaces best if mag > best_mag (strict), so ties keep the lower bin.
  - best_mag/best_bin are cleared to 0 at the first bin of each frame.
- FSM:
  - IDLE: in_valid -> COLLECT (bin 0 accepted).
  - COLLECT: counts bins; the in_valid carrying bin N-1 -> DRAIN.
  - DRAIN: two cycles while the pipeline empties -> REPORT.
  - REPORT: one cycle. peak_valid=1, and peak_bin/peak_mag/peak_found are loaded from best. -> IDLE.
- Latency: if edge e samples bin N-1, peak_valid is high in the cycle following edge e+3. Outputs hold their values until the next REPORT.
- in_valid in DRAIN/REPORT: the data is ignored, overrun is set (sticky until reset), and the state sequence is unchanged.
- in_valid in IDLE is always accepted as bin 0 of a new frame.
- busy=1 in COLLECT, DRAIN and REPORT.

Optional Feature:
- Macro PEAK_THRESH_EN.
- Defined: at REPORT, peak_found = (best_mag >= THRESH). If not found, peak_bin and peak_mag are forced to 0 (peak_valid still pulses).
- Undefined: peak_found=1 at every REPORT; THRESH is unused; no comparator is generated.

Test Plan:
- Tone frame: bin 5 = (re=-300, im=100) → mag 350; all other bins (10,0) → mag 10. Expect peak_valid pulse 4 cycles after bin 31 is sampled, peak_bin=5, peak_mag=350, overrun=0.
- DC exclusion and mirror: bin 0 = (20000,0), bin 27 = (5000,5000), bin 3 = (1000,0), rest 0. Expect peak_bin=3, peak_mag=1000.
- Saturation and ties: bin 4 = (-32768,-32768) and bin 9 = (32767,32767). Both give mag 49150; expect peak_bin=4, peak_mag=49150.
- Gapped valid and back-to-back frames: frame 1 sent with in_valid every other cycle, frame 2 sent 1 cycle after REPORT. Expect two correct reports, with frame 2's best-tracking uncorrupted by frame 1.
- Mid-frame reset and overrun:
  - Reset after bin 12: busy=0 next cycle and no peak_valid; the following full frame reports correctly.
  - in_valid during DRAIN: overrun=1 and stays high.
- PEAK_THRESH_EN with THRESH=64:
  - Peak mag 50 → peak_found=0, peak_bin=0, peak_mag=0.
  - Peak mag 64 → peak_found=1.
  - Without the macro, the mag-50 frame gives peak_found=1, peak_mag=50.
